if_id_stage: RTL and testbench

//  IF/ID pipeline register with load-use hazard detection for the 5-stage RV32 core.

---
 rtl/if_id_stage_pkg.sv | 26 ++
 rtl/if_id_stage_hazard_detect.sv | 26 ++
 rtl/if_id_stage.sv | 125 ++++++++++++
 tb/tb_if_id_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the IF/ID stage: RV32 opcode constants, the NOP used to
// squash the stage, and the stage FSM encoding.
package if_id_stage_pkg;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        STALL = 2'b10
    } if_id_state_t;

    // Only R-type, store and branch formats actually read rs2; in every other
    // format bits [24:20] are immediate bits and must not trigger a stall.
    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OPC_RTYPE) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/if_id_stage_hazard_detect.sv
// Load-use hazard detection: flags when the instruction held in ID reads a register
// that the load currently in EX has not yet produced.
module hazard_detect
    import if_id_stage_pkg::*;
(
    input  logic       run_active,
    input  logic       id_valid,
    input  logic [6:0] id_opcode,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       idex_memread,
    input  logic [4:0] idex_rd,
    output logic       hazard
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = (idex_rd == id_rs1);
    assign rs2_match = uses_rs2(id_opcode) && (idex_rd == id_rs2);

    // x0 never carries a dependency, so a load targeting it cannot stall anything.
    assign hazard = run_active && id_valid && idex_memread && (idex_rd != 5'd0) &&
                    (rs1_match || rs2_match);

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use stall generation for the 5-stage RV32 core.
// Optional PIPE_STATS_EN adds saturating stall/flush event counters.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     instr_i,
    input  logic            flush_i,
    input  logic            idex_memread_i,
    input  logic [4:0]      idex_rd_i,
    output logic [XLEN-1:0] pc_o,
    output logic [31:0]     instr_o,
    output logic [16:0]     ctrl_key_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic            valid_o,
    output logic            pc_write_o,
    output logic            stall_o
`ifdef PIPE_STATS_EN
    ,
    output logic [31:0]     stall_cnt_o,
    output logic [31:0]     flush_cnt_o
`endif
);

    if_id_state_t    state_q;
    if_id_state_t    state_d;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_q;
    logic            valid_q;

    logic            hazard_raw;
    logic            hazard;
    logic            load_en;
    logic            flush_accept;

    hazard_detect u_hazard_detect (
        .run_active   (state_q == RUN),
        .id_valid     (valid_q),
        .id_opcode    (instr_q[6:0]),
        .id_rs1       (instr_q[19:15]),
        .id_rs2       (instr_q[24:20]),
        .idex_memread (idex_memread_i),
        .idex_rd      (idex_rd_i),
        .hazard       (hazard_raw)
    );

    // Dropping start_i outranks a hazard, so the stall request is masked too.
    assign hazard       = hazard_raw && start_i;
    assign load_en      = start_i && !hazard;
    assign flush_accept = load_en && flush_i;

    assign pc_write_o = load_en;
    assign stall_o    = hazard;

    always_comb begin
        state_d = state_q;
        if (!start_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = hazard ? STALL : RUN;
                STALL:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_en) begin
                pc_q    <= pc_i;
                instr_q <= flush_i ? NOP_INSTR : instr_i;
                valid_q <= !flush_i;
            end
        end
    end

    assign pc_o       = pc_q;
    assign instr_o    = instr_q;
    assign valid_o    = valid_q;
    assign ctrl_key_o = {instr_q[31:25], instr_q[14:12], instr_q[6:0]};
    assign rs1_o      = instr_q[19:15];
    assign rs2_o      = instr_q[24:20];
    assign rd_o       = instr_q[11:7];

`ifdef PIPE_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (hazard && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_accept && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    logic unused_flush_accept;
    assign unused_flush_accept = flush_accept;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed testbench for if_id_stage: reset, flow, load-use stalls, false-stall
// avoidance, flush and flush-vs-hazard priority, hold on start drop, reset mid-stall.
module tb_if_id_stage;

    localparam int XLEN = 32;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] ADD_X3   = 32'h0020_81B3;  // add  x3,x1,x2
    localparam logic [31:0] ADD_X5   = 32'h0062_02B3;  // add  x5,x4,x6
    localparam logic [31:0] SUB_X7   = 32'h4020_83B3;  // sub  x7,x1,x2
    localparam logic [31:0] ADDI_X5  = 32'h0040_0293;  // addi x5,x0,4

    logic            clk_i;
    logic            rst_i;
    logic            start_i;
    logic [XLEN-1:0] pc_i;
    logic [31:0]     instr_i;
    logic            flush_i;
    logic            idex_memread_i;
    logic [4:0]      idex_rd_i;
    logic [XLEN-1:0] pc_o;
    logic [31:0]     instr_o;
    logic [16:0]     ctrl_key_o;
    logic [4:0]      rs1_o;
    logic [4:0]      rs2_o;
    logic [4:0]      rd_o;
    logic            valid_o;
    logic            pc_write_o;
    logic            stall_o;
`ifdef PIPE_STATS_EN
    logic [31:0]     stall_cnt_o;
    logic [31:0]     flush_cnt_o;
`endif

    int checkCount = 0;
    int failCount  = 0;

    if_id_stage #(.XLEN(XLEN)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .pc_i           (pc_i),
        .instr_i        (instr_i),
        .flush_i        (flush_i),
        .idex_memread_i (idex_memread_i),
        .idex_rd_i      (idex_rd_i),
        .pc_o           (pc_o),
        .instr_o        (instr_o),
        .ctrl_key_o     (ctrl_key_o),
        .rs1_o          (rs1_o),
        .rs2_o          (rs2_o),
        .rd_o           (rd_o),
        .valid_o        (valid_o),
        .pc_write_o     (pc_write_o),
        .stall_o        (stall_o)
`ifdef PIPE_STATS_EN
        ,
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Inputs change 1 time unit after a rising edge and are checked there as well.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic start, input logic flush, input logic memread,
                                 input logic [4:0] exRd, input logic [31:0] pc,
                                 input logic [31:0] instr);
        start_i        = start;
        flush_i        = flush;
        idex_memread_i = memread;
        idex_rd_i      = exRd;
        pc_i           = pc;
        instr_i        = instr;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);

        // Reset held for two cycles with the pipeline not running.
        tick();
        tick();
        checkOutput("reset_instr", instr_o, NOP);
        checkOutput("reset_valid", {31'd0, valid_o}, 32'd0);
        checkOutput("reset_pc", pc_o, 32'd0);
        checkOutput("reset_pcwrite", {31'd0, pc_write_o}, 32'd0);
        checkOutput("reset_stall", {31'd0, stall_o}, 32'd0);

        // Basic flow: add x3,x1,x2 at 0x4.
        rst_i = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h4, ADD_X3);
        checkOutput("idle_start_pcwrite", {31'd0, pc_write_o}, 32'd1);
        tick();
        checkOutput("flow_instr", instr_o, ADD_X3);
        checkOutput("flow_key", {15'd0, ctrl_key_o}, 32'h0_0033);
        checkOutput("flow_rs1", {27'd0, rs1_o}, 32'd1);
        checkOutput("flow_rs2", {27'd0, rs2_o}, 32'd2);
        checkOutput("flow_rd", {27'd0, rd_o}, 32'd3);
        checkOutput("flow_valid", {31'd0, valid_o}, 32'd1);
        checkOutput("flow_stall", {31'd0, stall_o}, 32'd0);
        checkOutput("flow_pc", pc_o, 32'h4);

        // Load-use through rs1: ID holds add x5,x4,x6, EX loads x4.
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h8, ADD_X5);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd4, 32'hC, SUB_X7);
        checkOutput("lu1_stall", {31'd0, stall_o}, 32'd1);
        checkOutput("lu1_pcwrite", {31'd0, pc_write_o}, 32'd0);
        tick();
        checkOutput("lu1_hold_instr", instr_o, ADD_X5);
        checkOutput("lu1_hold_pc", pc_o, 32'h8);
        checkOutput("lu1_second_stall", {31'd0, stall_o}, 32'd0);
        checkOutput("lu1_second_pcwrite", {31'd0, pc_write_o}, 32'd1);
        tick();
        checkOutput("lu1_resume_instr", instr_o, SUB_X7);
        checkOutput("lu1_resume_pc", pc_o, 32'hC);
        checkOutput("sub_key", {15'd0, ctrl_key_o}, 32'h0_8033);

        // Load-use through rs2 (x6) of an R-type.
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h10, ADD_X5);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd6, 32'h14, ADDI_X5);
        checkOutput("lu2_stall", {31'd0, stall_o}, 32'd1);
        tick();
        checkOutput("lu2_hold_instr", instr_o, ADD_X5);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h14, ADDI_X5);
        tick();
        checkOutput("lu2_resume_instr", instr_o, ADDI_X5);

        // I-type: rs2 field equals the load's rd, rs1 is x0; neither may stall.
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd4, 32'h18, ADD_X3);
        checkOutput("itype_rs2field_stall", {31'd0, stall_o}, 32'd0);
        checkOutput("itype_rs2field_pcwrite", {31'd0, pc_write_o}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd0, 32'h18, ADD_X3);
        checkOutput("rd_x0_stall", {31'd0, stall_o}, 32'd0);

        // Flush squashes to NOP but still takes the new PC.
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 32'h18, ADD_X3);
        tick();
        checkOutput("flush_instr", instr_o, NOP);
        checkOutput("flush_valid", {31'd0, valid_o}, 32'd0);
        checkOutput("flush_pc", pc_o, 32'h18);
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd0, 32'h1C, ADD_X5);
        checkOutput("nop_no_stall", {31'd0, stall_o}, 32'd0);

        // Flush coincident with a hazard is ignored.
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h1C, ADD_X5);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 5'd4, 32'h20, ADD_X3);
        checkOutput("flushhaz_stall", {31'd0, stall_o}, 32'd1);
        tick();
        checkOutput("flushhaz_instr", instr_o, ADD_X5);
        checkOutput("flushhaz_valid", {31'd0, valid_o}, 32'd1);
        checkOutput("flushhaz_pc", pc_o, 32'h1C);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h20, ADD_X3);
        tick();
        checkOutput("after_flushhaz_instr", instr_o, ADD_X3);

        // Second accepted flush.
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 32'h24, SUB_X7);
        tick();
        checkOutput("flush2_instr", instr_o, NOP);
        checkOutput("flush2_pc", pc_o, 32'h24);

        // Dropping start_i holds the register and suppresses stall even on a match.
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h28, ADD_X5);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd4, 32'h2C, SUB_X7);
        checkOutput("stop_pcwrite", {31'd0, pc_write_o}, 32'd0);
        checkOutput("stop_stall", {31'd0, stall_o}, 32'd0);
        tick();
        checkOutput("stop_hold_instr", instr_o, ADD_X5);
        checkOutput("stop_hold_pc", pc_o, 32'h28);

`ifdef PIPE_STATS_EN
        checkOutput("stats_stall_cnt", stall_cnt_o, 32'd3);
        checkOutput("stats_flush_cnt", flush_cnt_o, 32'd2);
`endif

        // Restart from IDLE: hazard logic is inactive until state reaches RUN.
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd4, 32'h2C, SUB_X7);
        checkOutput("idle_no_stall", {31'd0, stall_o}, 32'd0);
        tick();
        checkOutput("restart_instr", instr_o, SUB_X7);

        // Reset arriving while a stall is pending.
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h30, ADD_X5);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd6, 32'h34, ADD_X3);
        checkOutput("pre_reset_stall", {31'd0, stall_o}, 32'd1);
        tick();
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        #1;
        checkOutput("midreset_instr", instr_o, NOP);
        checkOutput("midreset_valid", {31'd0, valid_o}, 32'd0);
        checkOutput("midreset_pc", pc_o, 32'd0);
        checkOutput("midreset_stall", {31'd0, stall_o}, 32'd0);
`ifdef PIPE_STATS_EN
        checkOutput("midreset_stall_cnt", stall_cnt_o, 32'd0);
`endif
        tick();
        checkOutput("post_reset_load", instr_o, ADD_X3);
        checkOutput("post_reset_valid", {31'd0, valid_o}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
